// File: rtl/onchip_ram_block_mover.sv
// onchip_ram_block_mover
// ---------------------------------------------------------------------------
// Avalon-MM initiator that moves a block of consecutive words between a
// 1024x32 single-port on-chip RAM (read latency 1, no waitrequest) and a
// valid/ready stream, in either direction.
//
// Ports
//   clk_i, reset_i            : clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o : command handshake (accepted only in IDLE)
//   cmd_write_i               : 1 = stream -> RAM, 0 = RAM -> stream
//   cmd_addr_i, cmd_len_i     : start word address, word count (0..1024)
//   busy_o, done_o            : transfer active, one-cycle completion pulse
//   sink_*                    : write-mode stream input
//   src_*                     : read-mode stream output
//   avm_*                     : Avalon-MM initiator towards the RAM slave
// ---------------------------------------------------------------------------
module onchip_ram_block_mover #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_W-1:0]     cmd_addr_i,
  input  logic [LEN_W-1:0]      cmd_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [DATA_W-1:0]     sink_data_i,
  input  logic                  sink_valid_i,
  output logic                  sink_ready_o,
  output logic [DATA_W-1:0]     src_data_o,
  output logic                  src_valid_o,
  input  logic                  src_ready_i,
  output logic [ADDR_W-1:0]     avm_address_o,
  output logic                  avm_chipselect_o,
  output logic                  avm_write_o,
  output logic [DATA_W/8-1:0]   avm_byteenable_o,
  output logic [DATA_W-1:0]     avm_writedata_o,
  input  logic [DATA_W-1:0]     avm_readdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  // Control state
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;       // next RAM address to use
  logic [LEN_W-1:0]    remain_q, remain_d;   // words left to accept / issue

  // Registered write strobe
  logic                wr_cs_q, wr_cs_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  // Read path: in-flight flag and 2-entry FIFO
  logic                inflight_q, inflight_d;
  logic [DATA_W-1:0]   fifo_mem_q [0:1];
  logic [DATA_W-1:0]   fifo_mem_d [0:1];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          fifo_cnt_q, fifo_cnt_d;

  // Handshake and issue decode
  logic                remain_nz_s;
  logic                cmd_fire_s;
  logic                sink_fire_s;
  logic                push_s;
  logic                pop_s;
  logic [2:0]          occ_s;
  logic                rd_issue_s;

  assign remain_nz_s = (remain_q != LEN_ZERO);
  assign cmd_fire_s  = cmd_ready_o & cmd_valid_i;
  assign sink_fire_s = sink_ready_o & sink_valid_i;
  assign push_s      = inflight_q;
  assign pop_s       = src_valid_o & src_ready_i;

  // Words that will still occupy the FIFO at the end of this cycle (the
  // in-flight word lands, a popped word leaves). Crediting the pop keeps one
  // word per cycle flowing with src_ready held high while never exceeding
  // two unconsumed strobes.
  assign occ_s      = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign rd_issue_s = ~reset_i & (state_q == ST_READ) & remain_nz_s & (occ_s < 3'd2);

  // Outputs: state decodes and registered strobes; handshake-type outputs
  // are masked by reset so nothing is accepted or issued in a reset cycle.
  assign cmd_ready_o      = (state_q == ST_IDLE) & ~reset_i;
  assign busy_o           = (state_q != ST_IDLE);
  assign done_o           = (state_q == ST_DONE);
  assign sink_ready_o     = ~reset_i & (state_q == ST_WRITE) & remain_nz_s;
  assign src_valid_o      = (fifo_cnt_q != 2'd0);
  assign src_data_o       = fifo_mem_q[rd_ptr_q];
  assign avm_chipselect_o = ~reset_i & (wr_cs_q | rd_issue_s);
  assign avm_write_o      = ~reset_i & wr_cs_q;
  assign avm_address_o    = rd_issue_s ? addr_q : wr_addr_q;
  assign avm_byteenable_o = {(DATA_W/8){1'b1}};
  assign avm_writedata_o  = wr_data_q;

  // Read FIFO next-state: capture read data one cycle after its strobe.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push_s) begin
      fifo_mem_d[wr_ptr_q] = avm_readdata_i;
      wr_ptr_d             = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    fifo_cnt_d = fifo_cnt_q + {1'b0, push_s} - {1'b0, pop_s};
  end

  // Transfer FSM next-state and write-strobe generation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    wr_cs_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    inflight_d = rd_issue_s;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire_s) begin
          addr_d   = cmd_addr_i;
          remain_d = cmd_len_i;
          if (cmd_len_i == LEN_ZERO) begin
            state_d = ST_DONE;
          end else if (cmd_write_i) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (sink_fire_s) begin
          // Register the access; it appears on the bus next cycle.
          wr_cs_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = sink_data_i;
          addr_d    = addr_q + ADDR_ONE;
          remain_d  = remain_q - LEN_ONE;
        end else if (!remain_nz_s) begin
          // Last strobe is on the bus this cycle.
          state_d = ST_DONE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        if (rd_issue_s) begin
          addr_d   = addr_q + ADDR_ONE;
          remain_d = remain_q - LEN_ONE;
        end else if (!remain_nz_s && !inflight_q && (fifo_cnt_q == 2'd0)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      addr_q        <= ADDR_ZERO;
      remain_q      <= LEN_ZERO;
      wr_cs_q       <= 1'b0;
      wr_addr_q     <= ADDR_ZERO;
      wr_data_q     <= DATA_ZERO;
      inflight_q    <= 1'b0;
      fifo_mem_q[0] <= DATA_ZERO;
      fifo_mem_q[1] <= DATA_ZERO;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remain_q      <= remain_d;
      wr_cs_q       <= wr_cs_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      inflight_q    <= inflight_d;
      fifo_mem_q[0] <= fifo_mem_d[0];
      fifo_mem_q[1] <= fifo_mem_d[1];
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_onchip_ram_block_mover.sv
// Directed testbench for onchip_ram_block_mover with a behavioural
// 1024x32 RAM slave (read latency 1) and a negedge bus monitor.
module tb_onchip_ram_block_mover;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic        busy;
  logic        done;
  logic [31:0] sink_data;
  logic        sink_valid;
  logic        sink_ready;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [9:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  always #5 clk = ~clk;

  onchip_ram_block_mover #(.ADDR_W(10), .DATA_W(32), .LEN_W(11)) dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .busy_o(busy), .done_o(done),
    .sink_data_i(sink_data), .sink_valid_i(sink_valid), .sink_ready_o(sink_ready),
    .src_data_o(src_data), .src_valid_o(src_valid), .src_ready_i(src_ready),
    .avm_address_o(avm_address), .avm_chipselect_o(avm_chipselect),
    .avm_write_o(avm_write), .avm_byteenable_o(avm_byteenable),
    .avm_writedata_o(avm_writedata), .avm_readdata_i(avm_readdata)
  );

  // RAM slave model
  logic [31:0] ram [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'hC000_0000 | i;
    avm_readdata = 32'h0;
  end
  always @(posedge clk) begin
    if (avm_chipselect) begin
      if (avm_write) ram[avm_address] <= avm_writedata;
      else           avm_readdata     <= ram[avm_address];
    end
  end

  // Cycle counter and bus monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_addr_log [$];
  logic [31:0] wr_data_log [$];
  int          wr_cyc_log  [$];
  logic [31:0] src_log     [$];
  int          src_cyc_log [$];
  int rd_strobes, cs_total, done_total, done_last, be_bad;
  int issued_t, popped_t, max_out, first_valid;

  always @(negedge clk) begin
    if (avm_chipselect) begin
      cs_total++;
      if (avm_byteenable !== 4'hF) be_bad++;
      if (avm_write) begin
        wr_addr_log.push_back(int'(avm_address));
        wr_data_log.push_back(avm_writedata);
        wr_cyc_log.push_back(cyc);
      end else begin
        rd_strobes++;
        issued_t++;
      end
    end
    if (src_valid && first_valid < 0) first_valid = cyc;
    if (src_valid && src_ready) begin
      src_log.push_back(src_data);
      src_cyc_log.push_back(cyc);
      popped_t++;
    end
    if (issued_t - popped_t > max_out) max_out = issued_t - popped_t;
    if (done) begin
      done_total++;
      done_last = cyc;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete();
    src_log.delete(); src_cyc_log.delete();
    rd_strobes = 0; cs_total = 0; done_total = 0; done_last = -1; be_bad = 0;
    issued_t = 0; popped_t = 0; max_out = 0; first_valid = -1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic do_cmd(input logic wr, input logic [9:0] a, input logic [10:0] l,
                        output int acc);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    chk("cmd_ready_before_accept", {31'b0, cmd_ready}, 32'd1);
    acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = 10'h155; cmd_len = 11'd7; cmd_write = ~wr;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(tag, {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic write_block(input logic [9:0] a, input logic [31:0] base, output int acc);
    do_cmd(1'b1, a, 11'd4, acc);
    for (int i = 0; i < 4; i++) begin
      sink_data = base + i; sink_valid = 1'b1;
      @(negedge clk);
      chk("wr_sink_ready", {31'b0, sink_ready}, 32'd1);
      chk("wr_cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
    end
    sink_valid = 1'b0; sink_data = 32'h0;
    @(negedge clk);
    chk("wr_sink_ready_drop", {31'b0, sink_ready}, 32'd0);
  endtask

  int acc;
  logic [5:0]  pat = 6'b101001;
  logic [31:0] exp6 [0:5];
  logic [9:0]  wrap_addr [0:3];

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 10'h0; cmd_len = 11'h0;
    sink_data = 32'h0; sink_valid = 1'b0; src_ready = 1'b0;
    exp6[0] = 32'hA0; exp6[1] = 32'hA1; exp6[2] = 32'hA2; exp6[3] = 32'hA3;
    exp6[4] = 32'hC000_0014; exp6[5] = 32'hC000_0015;
    wrap_addr[0] = 10'd1022; wrap_addr[1] = 10'd1023; wrap_addr[2] = 10'd0; wrap_addr[3] = 10'd1;
    clear_logs();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_cs", {31'b0, avm_chipselect}, 32'd0);
    chk("rst_write", {31'b0, avm_write}, 32'd0);
    chk("rst_addr", {22'b0, avm_address}, 32'd0);
    chk("rst_wdata", avm_writedata, 32'd0);
    chk("rst_sink_ready", {31'b0, sink_ready}, 32'd0);
    chk("rst_src_valid", {31'b0, src_valid}, 32'd0);
    chk("rst_src_data", src_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Write 4 words at 0x010
    clear_logs();
    write_block(10'h010, 32'hA0, acc);
    wait_idle("t1_idle");
    chk("t1_n_wr", wr_addr_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
      chk("t1_wr_addr", wr_addr_log[i], 32'h10 + i);
      chk("t1_wr_data", wr_data_log[i], 32'hA0 + i);
      chk("t1_wr_cyc", wr_cyc_log[i], acc + 2 + i);
    end
    chk("t1_be", be_bad, 32'd0);
    chk("t1_done_cnt", done_total, 32'd1);
    chk("t1_done_cyc", done_last, acc + 6);
    chk("t1_no_reads", rd_strobes, 32'd0);

    // Read 4 words at 0x010, src_ready high
    clear_logs();
    src_ready = 1'b1;
    do_cmd(1'b0, 10'h010, 11'd4, acc);
    wait_idle("t2_idle");
    chk("t2_first_valid", first_valid, acc + 3);
    chk("t2_n_src", src_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < src_log.size(); i++) begin
      chk("t2_src_data", src_log[i], 32'hA0 + i);
      chk("t2_src_cyc", src_cyc_log[i], acc + 3 + i);
    end
    chk("t2_done_cnt", done_total, 32'd1);
    chk("t2_rd_strobes", rd_strobes, 32'd4);

    // Read 6 words with src_ready toggling 1,0,0,1,0,1
    clear_logs();
    do_cmd(1'b0, 10'h010, 11'd6, acc);
    for (int k = 0; k < 200; k++) begin
      src_ready = pat[k % 6];
      @(negedge clk);
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("t3_idle", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("t3_n_src", src_log.size(), 32'd6);
    for (int i = 0; i < 6 && i < src_log.size(); i++) chk("t3_src_data", src_log[i], exp6[i]);
    chk("t3_max_outstanding_le2", {31'b0, max_out <= 2}, 32'd1);
    chk("t3_rd_strobes", rd_strobes, 32'd6);
    chk("t3_done_cnt", done_total, 32'd1);

    // Wrapping write at 1022 and read back
    clear_logs();
    src_ready = 1'b0;
    write_block(10'd1022, 32'hB0, acc);
    wait_idle("t4_idle");
    chk("t4_n_wr", wr_addr_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
      chk("t4_wr_addr", wr_addr_log[i], {22'b0, wrap_addr[i]});
      chk("t4_wr_data", wr_data_log[i], 32'hB0 + i);
    end
    clear_logs();
    src_ready = 1'b1;
    do_cmd(1'b0, 10'd1022, 11'd4, acc);
    wait_idle("t4r_idle");
    chk("t4r_n_src", src_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < src_log.size(); i++) chk("t4r_src_data", src_log[i], 32'hB0 + i);

    // Zero-length command
    clear_logs();
    do_cmd(1'b1, 10'h003, 11'd0, acc);
    @(negedge clk);
    chk("t5_done_c1", {31'b0, done}, 32'd1);
    chk("t5_busy_c1", {31'b0, busy}, 32'd1);
    chk("t5_cmd_ready_c1", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_done_c2", {31'b0, done}, 32'd0);
    chk("t5_cmd_ready_c2", {31'b0, cmd_ready}, 32'd1);
    chk("t5_no_cs", cs_total, 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of an 8-word read
    clear_logs();
    src_ready = 1'b1;
    do_cmd(1'b0, 10'h000, 11'd8, acc);
    repeat (4) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    reset = 1'b1; src_ready = 1'b0;
    @(negedge clk);
    chk("t6_rstcyc_cs", {31'b0, avm_chipselect}, 32'd0);
    chk("t6_rstcyc_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_src_valid", {31'b0, src_valid}, 32'd0);
    chk("t6_src_data", src_data, 32'd0);
    chk("t6_cs", {31'b0, avm_chipselect}, 32'd0);
    chk("t6_addr", {22'b0, avm_address}, 32'd0);
    chk("t6_wdata", avm_writedata, 32'd0);
    chk("t6_sink_ready", {31'b0, sink_ready}, 32'd0);
    chk("t6_done", {31'b0, done}, 32'd0);
    chk("t6_n_src", src_log.size(), 32'd2);
    if (src_log.size() >= 2) begin
      chk("t6_src0", src_log[0], 32'hB2);
      chk("t6_src1", src_log[1], 32'hB3);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_post_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("t6_post_src_valid", {31'b0, src_valid}, 32'd0);
    @(posedge clk); #1;
    clear_logs();
    src_ready = 1'b1;
    do_cmd(1'b0, 10'h010, 11'd2, acc);
    wait_idle("t6n_idle");
    chk("t6n_n_src", src_log.size(), 32'd2);
    for (int i = 0; i < 2 && i < src_log.size(); i++) chk("t6n_src_data", src_log[i], 32'hA0 + i);
    chk("t6n_done_cnt", done_total, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
